// File: rtl/frame_window_capture.sv
// frame_window_capture: after N skipped frames, writes one windowed frame (channel/RGB565, optional 2x2 decimation) to memory
module frame_window_capture #(
  parameter int COLOR_W     = 10,
  parameter int MEM_DW      = 16,
  parameter int MEM_AW      = 20,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SKIP_FRAMES = 300,
  parameter int FRAME_X     = 143,
  parameter int FRAME_Y     = 34
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  input  logic [12:0]        iX,
  input  logic [12:0]        iY,
  input  logic               iStart,
  input  logic [1:0]         iMode,
  input  logic               iDecim,
  output logic [MEM_AW-1:0]  oMemAddr,
  output logic [MEM_DW-1:0]  oMemData,
  output logic               oMemWE,
  output logic               oStopCapture,
  output logic               oBusy,
  output logic               oDone,
  output logic [MEM_AW-1:0]  oWordCount
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
  localparam int AW1 = MEM_AW + 1;
  state_t             r_state;
  logic [15:0]        r_cnt;
  logic [1:0]         r_mode;
  logic               r_decim;
  logic [MEM_AW-1:0]  r_addr;
  logic [MEM_DW-1:0]  r_data;
  logic               r_we;
  logic               r_stop;
  logic               r_done;
  logic [MEM_AW-1:0]  r_wc;
  logic               w_mark;
  logic               w_hit;
  logic               w_wr;
  logic [12:0]        w_dx;
  logic [12:0]        w_dy;
  logic [MEM_AW-1:0]  w_addr;
  logic [15:0]        w_rgb;
  logic [MEM_DW-1:0]  w_data;
  assign w_mark = iX == 13'(FRAME_X) && iY == 13'(FRAME_Y);
  assign w_hit  = 32'(iX) >= H_START && 32'(iX) < H_START + H_RES &&
                  32'(iY) >= V_START && 32'(iY) < V_START + V_RES;
  assign w_dx   = iX - 13'(H_START);
  assign w_dy   = iY - 13'(V_START);
  assign w_wr   = r_state == CAPTURE && w_hit && (!r_decim || (!w_dx[0] && !w_dy[0]));
  // computed one bit wider than the port, then truncated
  assign w_addr = MEM_AW'(r_decim ? AW1'(w_dx[12:1]) + AW1'(H_RES / 2) * AW1'(w_dy[12:1])
                                  : AW1'(w_dx) + AW1'(H_RES) * AW1'(w_dy));
  assign w_rgb  = {iRed[COLOR_W-1-:5], iGreen[COLOR_W-1-:6], iBlue[COLOR_W-1-:5]};
  assign w_data = r_mode == 2'd3 ? MEM_DW'(w_rgb)  :
                  r_mode == 2'd2 ? MEM_DW'(iBlue)  :
                  r_mode == 2'd1 ? MEM_DW'(iGreen) : MEM_DW'(iRed);
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_decim <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_stop  <= 1'b0;
      r_done  <= 1'b0;
      r_wc    <= '0;
    end else begin
      r_we   <= w_wr;
      r_stop <= r_state == CAPTURE;
      if (w_wr) begin
        r_addr <= w_addr;
        r_data <= w_data;
        r_wc   <= r_wc + 1'b1;
      end
      case (r_state)
        IDLE, DONE: if (iStart) begin
          r_state <= ARM;
          r_cnt   <= '0;
          r_wc    <= '0;
          r_mode  <= iMode;
          r_decim <= iDecim;
          r_done  <= 1'b0;
        end
        ARM: if (w_mark) begin
          if (r_cnt == 16'(SKIP_FRAMES)) r_state <= CAPTURE;
          else r_cnt <= r_cnt + 1'b1;
        end
        CAPTURE: if (w_mark) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign oMemAddr     = r_addr;
  assign oMemData     = r_data;
  assign oMemWE       = r_we;
  assign oStopCapture = r_stop;
  assign oBusy        = r_state == ARM || r_state == CAPTURE;
  assign oDone        = r_done;
  assign oWordCount   = r_wc;
endmodule

// File: tb/tb_frame_window_capture.sv
// tb_frame_window_capture: directed table of captures on an 8x6 raster plus start/restart/reset sequences
module tb_frame_window_capture;
  logic        clk = 1'b0;
  logic        rst, start, decim;
  logic [1:0]  mode;
  logic [9:0]  r, g, b;
  logic [12:0] x, y;
  logic [7:0]  addr, wc;
  logic [15:0] data;
  logic        we, stop, busy, done;
  int n_chk = 0, n_fail = 0;
  int px = 0, py = 0, pat = 0;
  logic [7:0]  q_a[$];
  logic [15:0] q_d[$];
  typedef struct {
    logic [1:0]        mode;
    logic              decim;
    int                pat;
    int                n;
    logic [7:0][7:0]   a;
    logic [7:0][15:0]  d;
  } vec_t;
  vec_t vec[6];
  always #5 clk = ~clk;
  frame_window_capture #(
    .COLOR_W(10), .MEM_DW(16), .MEM_AW(8), .H_START(2), .V_START(1), .H_RES(4), .V_RES(2),
    .SKIP_FRAMES(2), .FRAME_X(0), .FRAME_Y(0)
  ) dut (
    .iCLK(clk), .iRST(rst), .iRed(r), .iGreen(g), .iBlue(b), .iX(x), .iY(y),
    .iStart(start), .iMode(mode), .iDecim(decim),
    .oMemAddr(addr), .oMemData(data), .oMemWE(we), .oStopCapture(stop),
    .oBusy(busy), .oDone(done), .oWordCount(wc)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cycle();
    x = 13'(px);
    y = 13'(py);
    r = pat != 0 ? 10'h3FF : 10'(px + 16 * py);
    g = pat != 0 ? 10'h000 : 10'h2AA;
    b = pat != 0 ? 10'h3FF : 10'h155;
    @(posedge clk);
    #1;
    if (we) begin
      q_a.push_back(addr);
      q_d.push_back(data);
      chk("wc_track", 32'(wc), 32'(q_a.size()));
      chk("stop_during_we", 32'(stop), 1);
    end
    px = px == 7 ? 0 : px + 1;
    if (px == 0) py = py == 5 ? 0 : py + 1;
  endtask
  task automatic start_pulse(input logic [1:0] m, input logic d);
    start = 1'b1;
    mode  = m;
    decim = d;
    cycle();
    start = 1'b0;
    mode  = m ^ 2'd2;
    decim = ~d;
    chk("busy_after_start", 32'(busy), 1);
    chk("done_cleared", 32'(done), 0);
  endtask
  task automatic run_to_done();
    for (int i = 0; i < 500 && !done; i++) cycle();
    chk("done_seen", 32'(done), 1);
  endtask
  initial begin
    vec[0] = '{mode: 2'd0, decim: 1'b0, pat: 0, n: 8,
               a: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
               d: {16'h25, 16'h24, 16'h23, 16'h22, 16'h15, 16'h14, 16'h13, 16'h12}};
    vec[1] = '{mode: 2'd0, decim: 1'b1, pat: 0, n: 2, a: {48'd0, 8'd1, 8'd0}, d: {96'd0, 16'h14, 16'h12}};
    vec[2] = '{mode: 2'd3, decim: 1'b0, pat: 1, n: 8,
               a: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, d: {8{16'hF81F}}};
    vec[3] = '{mode: 2'd1, decim: 1'b0, pat: 0, n: 8,
               a: {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, d: {8{16'h02AA}}};
    vec[4] = '{mode: 2'd2, decim: 1'b1, pat: 0, n: 2, a: {48'd0, 8'd1, 8'd0}, d: {96'd0, 16'h0155, 16'h0155}};
    vec[5] = '{mode: 2'd3, decim: 1'b1, pat: 0, n: 2, a: {48'd0, 8'd1, 8'd0}, d: {96'd0, 16'h054A, 16'h054A}};
    rst = 1'b1; start = 1'b0; mode = 2'd0; decim = 1'b0;
    cycle();
    cycle();
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stop", 32'(stop), 0);
    chk("rst_wc", 32'(wc), 0);
    rst = 1'b0;
    for (int v = 0; v < 6; v++) begin
      pat = vec[v].pat;
      q_a.delete();
      q_d.delete();
      start_pulse(vec[v].mode, vec[v].decim);
      run_to_done();
      chk($sformatf("v%0d_count", v), 32'(q_a.size()), 32'(vec[v].n));
      chk($sformatf("v%0d_wc", v), 32'(wc), 32'(vec[v].n));
      for (int i = 0; i < vec[v].n && i < q_a.size(); i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), 32'(q_a[i]), 32'(vec[v].a[i]));
        chk($sformatf("v%0d_data%0d", v, i), 32'(q_d[i]), 32'(vec[v].d[i]));
      end
      cycle();
      chk($sformatf("v%0d_stop_off", v), 32'(stop), 0);
      chk($sformatf("v%0d_done_sticky", v), 32'(done), 1);
    end
    pat = 0;
    q_a.delete();
    q_d.delete();
    start = 1'b1; mode = 2'd0; decim = 1'b0;
    for (int k = 0; k < 500; k++) begin
      cycle();
      if (done) break;
    end
    start = 1'b0;
    chk("held_done", 32'(done), 1);
    chk("held_count", 32'(q_a.size()), 8);
    chk("held_wc", 32'(wc), 8);
    repeat (60) cycle();
    chk("held_done_sticky", 32'(done), 1);
    chk("held_no_extra", 32'(q_a.size()), 8);
    q_a.delete();
    q_d.delete();
    start_pulse(2'd0, 1'b0);
    run_to_done();
    chk("restart_count", 32'(q_a.size()), 8);
    if (q_d.size() == 8) chk("restart_last_data", 32'(q_d[7]), 32'h25);
    q_a.delete();
    q_d.delete();
    start_pulse(2'd0, 1'b0);
    for (int k = 0; k < 500 && q_a.size() < 3; k++) cycle();
    chk("mid_three_we", 32'(q_a.size()), 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_data", 32'(data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_stop", 32'(stop), 0);
    chk("mid_rst_wc", 32'(wc), 0);
    repeat (250) cycle();
    chk("mid_no_more_we", 32'(q_a.size()), 3);
    chk("mid_idle", 32'(busy), 0);
    q_a.delete();
    q_d.delete();
    pat = 1;
    start_pulse(2'd3, 1'b1);
    run_to_done();
    chk("recover_count", 32'(q_a.size()), 2);
    if (q_d.size() == 2) chk("recover_data", 32'(q_d[1]), 32'hF81F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
